// File: rtl/game_pkg.sv
// Shared types and constants for the game round sequencer.
// Field layout of the 47-bit game input vector and the LFSR step.
package game_pkg;

    localparam int VEC_W = 47;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int SPEED_W     = 7;
    localparam int RANDOM1_W   = 7;
    localparam int EFFORT_W    = 7;
    localparam int RANDOM2_W   = 7;
    localparam int SLIDE_W     = 3;
    localparam int TIMING_W    = 3;
    localparam int LUCK3_W     = 3;
    localparam int BREAKFAST_W = 2;
    localparam int MOVEMENT_W  = 2;
    localparam int HARD_W      = 5;
    localparam int WEATHER_W   = 1;

    localparam int WEATHER_LO   = 0;
    localparam int HARD_LO      = WEATHER_LO + WEATHER_W;
    localparam int MOVEMENT_LO  = HARD_LO + HARD_W;
    localparam int BREAKFAST_LO = MOVEMENT_LO + MOVEMENT_W;
    localparam int LUCK3_LO     = BREAKFAST_LO + BREAKFAST_W;
    localparam int TIMING_LO    = LUCK3_LO + LUCK3_W;
    localparam int SLIDE_LO     = TIMING_LO + TIMING_W;
    localparam int RANDOM2_LO   = SLIDE_LO + SLIDE_W;
    localparam int EFFORT_LO    = RANDOM2_LO + RANDOM2_W;
    localparam int RANDOM1_LO   = EFFORT_LO + EFFORT_W;
    localparam int SPEED_LO     = RANDOM1_LO + RANDOM1_W;

    typedef enum logic [2:0] {
        IDLE,
        GEN_A,
        GEN_B,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// 32-bit Galois LFSR (right shift) with synchronous load and step enable.
// Load wins over step; the register holds when neither is asserted.
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [31:0] SEED_DEF = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED_DEF;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/game_round_sequencer.sv
// Runs NUM_ROUNDS pseudo-random rounds against the game and keeps
// pass/fail/streak scores.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int          NUM_ROUNDS = 16,
    parameter int          WAIT_CYC   = 2,
    parameter logic [31:0] SEED_DEF   = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        pass3,
    output logic [6:0]  speed,
    output logic [6:0]  random1,
    output logic [6:0]  effort,
    output logic [6:0]  random2,
    output logic [2:0]  slide,
    output logic [2:0]  timing,
    output logic [2:0]  luck3,
    output logic [1:0]  breakfast,
    output logic [1:0]  movement,
    output logic [4:0]  hard,
    output logic        weather,
    output logic        game_vld,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  best_streak
);

    localparam logic [7:0] WAIT_M1 = 8'(WAIT_CYC - 1);
    localparam logic [7:0] LAST_RND = 8'(NUM_ROUNDS - 1);

    state_t         state;
    logic [31:0]    lfsr;
    logic [31:0]    vec_lo;
    logic [VEC_W-1:0] game_vec;
    logic [7:0]     round;
    logic [7:0]     wait_cnt;
    logic [7:0]     cur_streak;
    logic [7:0]     streak_inc;
    logic           lfsr_step;
    logic           lfsr_load;
    logic [31:0]    load_val;

    assign lfsr_step  = !abort && (state == GEN_A || state == GEN_B);
    assign lfsr_load  = !abort && (state == IDLE) && seed_load;
    assign load_val   = (seed == 32'h0) ? SEED_DEF : seed;
    assign streak_inc = sat_inc(cur_streak);

    game_lfsr #(
        .SEED_DEF (SEED_DEF)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (load_val),
        .q        (lfsr)
    );

    // Game fields come from a separate register so they only move at GEN_B.
    assign speed     = game_vec[SPEED_LO     +: SPEED_W];
    assign random1   = game_vec[RANDOM1_LO   +: RANDOM1_W];
    assign effort    = game_vec[EFFORT_LO    +: EFFORT_W];
    assign random2   = game_vec[RANDOM2_LO   +: RANDOM2_W];
    assign slide     = game_vec[SLIDE_LO     +: SLIDE_W];
    assign timing    = game_vec[TIMING_LO    +: TIMING_W];
    assign luck3     = game_vec[LUCK3_LO     +: LUCK3_W];
    assign breakfast = game_vec[BREAKFAST_LO +: BREAKFAST_W];
    assign movement  = game_vec[MOVEMENT_LO  +: MOVEMENT_W];
    assign hard      = game_vec[HARD_LO      +: HARD_W];
    assign weather   = game_vec[WEATHER_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vec_lo      <= '0;
            game_vec    <= '0;
            round       <= '0;
            wait_cnt    <= '0;
            cur_streak  <= '0;
            best_streak <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            game_vld    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            game_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= GEN_A;
                        busy        <= 1'b1;
                        round       <= '0;
                        cur_streak  <= '0;
                        best_streak <= '0;
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                    end
                end
                GEN_A: begin
                    vec_lo <= lfsr;
                    state  <= GEN_B;
                end
                GEN_B: begin
                    game_vec <= {lfsr[VEC_W-33:0], vec_lo};
                    wait_cnt <= WAIT_M1;
                    game_vld <= 1'b1;
                    state    <= DRIVE;
                end
                DRIVE: begin
                    if (wait_cnt == 8'd0) begin
                        game_vld <= 1'b0;
                        state    <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (pass3) begin
                        pass_cnt   <= sat_inc(pass_cnt);
                        cur_streak <= streak_inc;
                        if (streak_inc > best_streak)
                            best_streak <= streak_inc;
                    end else begin
                        fail_cnt   <= sat_inc(fail_cnt);
                        cur_streak <= '0;
                    end
                    if (round == LAST_RND) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        round <= round + 8'd1;
                        state <= GEN_A;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer: run timing, scoring,
// seeding, abort, ignored mid-run controls and async reset.
module tb_game_round_sequencer;

    localparam logic [31:0] SEED_DEF = 32'hACE1_2024;
    localparam logic [31:0] TAPS     = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        seed_load;
    logic [31:0] seed;
    logic        pass3;
    logic [6:0]  speed, random1, effort, random2;
    logic [2:0]  slide, timing, luck3;
    logic [1:0]  breakfast, movement;
    logic [4:0]  hard;
    logic        weather;
    logic        game_vld, busy, done;
    logic [7:0]  pass_cnt, fail_cnt, best_streak;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mdl;
    logic [46:0] cur_vec;

    always #5 clk = ~clk;

    assign cur_vec = {speed, random1, effort, random2, slide, timing,
                      luck3, breakfast, movement, hard, weather};

    game_round_sequencer #(
        .NUM_ROUNDS (16),
        .WAIT_CYC   (2),
        .SEED_DEF   (SEED_DEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .seed_load   (seed_load),
        .seed        (seed),
        .pass3       (pass3),
        .speed       (speed),
        .random1     (random1),
        .effort      (effort),
        .random2     (random2),
        .slide       (slide),
        .timing      (timing),
        .luck3       (luck3),
        .breakfast   (breakfast),
        .movement    (movement),
        .hard        (hard),
        .weather     (weather),
        .game_vld    (game_vld),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .best_streak (best_streak)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? TAPS : 32'h0);
    endfunction

    // kind: 0 plain run, 1 abort at round hit, 2 reset pulse at round hit
    task automatic run(input int mode, input int hit, input int kind,
                       input bit ld, input logic [31:0] ld_val,
                       input bit inject, output int cyc,
                       output logic [46:0] fv);
        int rnd = -1;
        bit prev = 1'b0;
        bit stop = 1'b0;
        bit fin = 1'b0;
        logic [31:0] a, b;
        fv = '0;
        @(negedge clk);
        start = 1'b1;
        if (ld) begin
            seed_load = 1'b1;
            seed = ld_val;
            mdl = (ld_val == 32'h0) ? SEED_DEF : ld_val;
        end
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        seed_load = 1'b0;
        while (!fin && !stop && cyc < 300) begin
            @(negedge clk);
            if (done) begin
                fin = 1'b1;
            end else begin
                if (game_vld && !prev) begin
                    rnd++;
                    a = mdl;
                    mdl = step(mdl);
                    b = mdl;
                    mdl = step(mdl);
                    chk($sformatf("vec_r%0d", rnd), 64'(cur_vec),
                        64'({b[14:0], a}));
                    if (rnd == 0) fv = cur_vec;
                    pass3 = (mode == 0) ? 1'b1 :
                            !((rnd % 7) == 2 || (rnd % 7) == 6);
                    if (rnd == hit && kind == 1) abort = 1'b1;
                    if (rnd == hit && kind == 2) begin
                        #2 rst_n = 1'b0;
                        #1;
                        chk("rst_busy", 64'(busy), 0);
                        chk("rst_vld", 64'(game_vld), 0);
                        chk("rst_vec", 64'(cur_vec), 0);
                        chk("rst_pass", 64'(pass_cnt), 0);
                        chk("rst_lfsr", 64'(dut.u_lfsr.q), 64'(SEED_DEF));
                        @(posedge clk);
                        #1 rst_n = 1'b1;
                        stop = 1'b1;
                    end
                end
                prev = game_vld;
                if (inject && cyc == 30) begin
                    start = 1'b1;
                    seed_load = 1'b1;
                    seed = 32'h0000_1234;
                end
                if (!stop) begin
                    @(posedge clk);
                    cyc++;
                    #1 start = 1'b0;
                    seed_load = 1'b0;
                    if (abort) begin
                        abort = 1'b0;
                        stop = 1'b1;
                    end
                end
            end
        end
        chk("run_end", 64'(fin | stop), 1);
    endtask

    int cyc;
    logic [46:0] fv;
    bit seen;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed_load = 1'b0;
        seed = '0;
        pass3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("r_vec", 64'(cur_vec), 0);
        chk("r_busy", 64'(busy), 0);
        chk("r_vld", 64'(game_vld), 0);
        chk("r_done", 64'(done), 0);
        chk("r_pass", 64'(pass_cnt), 0);
        chk("r_fail", 64'(fail_cnt), 0);
        chk("r_best", 64'(best_streak), 0);
        chk("r_lfsr", 64'(dut.u_lfsr.q), 64'(SEED_DEF));
        rst_n = 1'b1;
        mdl = SEED_DEF;

        run(0, -1, 0, 0, 0, 0, cyc, fv);
        chk("t1_cyc", 64'(cyc), 81);
        chk("t1_pass", 64'(pass_cnt), 16);
        chk("t1_fail", 64'(fail_cnt), 0);
        chk("t1_best", 64'(best_streak), 16);
        @(negedge clk);
        chk("t1_done_end", 64'(done), 0);
        chk("t1_busy_end", 64'(busy), 0);

        seed = 32'h0;
        seed_load = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
        chk("t2_zero_seed", 64'(dut.u_lfsr.q), 64'(SEED_DEF));
        run(0, -1, 0, 1, 32'h1, 0, cyc, fv);
        chk("t2_first_vec", 64'(fv), 64'h3_0000_0001);
        chk("t2_cyc", 64'(cyc), 81);

        run(1, -1, 0, 0, 0, 0, cyc, fv);
        chk("t3_pass", 64'(pass_cnt), 12);
        chk("t3_fail", 64'(fail_cnt), 4);
        chk("t3_best", 64'(best_streak), 3);

        run(0, 4, 1, 0, 0, 0, cyc, fv);
        seen = 1'b0;
        @(negedge clk);
        chk("t4_busy", 64'(busy), 0);
        chk("t4_vld", 64'(game_vld), 0);
        chk("t4_pass", 64'(pass_cnt), 4);
        repeat (6) begin
            seen |= done;
            @(negedge clk);
        end
        chk("t4_no_done", 64'(seen), 0);

        run(0, -1, 0, 0, 0, 1, cyc, fv);
        chk("t5_cyc", 64'(cyc), 81);
        chk("t5_pass", 64'(pass_cnt), 16);

        run(0, 2, 2, 0, 0, 0, cyc, fv);
        mdl = SEED_DEF;
        run(0, -1, 0, 0, 0, 0, cyc, fv);
        chk("t6_replay", 64'(fv), 64'h1012_ACE1_2024);
        chk("t6_cyc", 64'(cyc), 81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
